// File: rtl/clutter_gate.sv
// Detection gate for the clutter remover: confirms consecutive threshold exceedances
// and queues detections toward the tracker. Optional stats counter: CLUTTER_GATE_STATS_EN.
module clutter_gate #(
  parameter int          DEPTH   = 4,
  parameter int          CONFIRM = 3,
  parameter logic [15:0] MARGIN  = 16'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic [15:0] intensity,
  input  logic [15:0] threshold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_intensity,
  output logic [15:0] out_excess,
  output logic [15:0] out_index
`ifdef CLUTTER_GATE_STATS_EN
  ,
  output logic [15:0] det_count
`endif
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [4:0]     CONF_C  = 5'(CONFIRM);

  logic [47:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    streak_q, streak_d;
  logic [15:0]   index_q;

  logic [16:0]   level_s;
  logic [15:0]   excess_s;
  logic [4:0]    streak_inc_s;
  logic          hit_s, det_s, accept_s, push_s, pop_s;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign {out_intensity, out_excess, out_index} = mem_q[rd_ptr_q];

  // Compare, streak tracking and FIFO occupancy next-state.
  always_comb begin
    level_s      = {1'b0, threshold} + {1'b0, MARGIN};
    hit_s        = ({1'b0, intensity} > level_s);
    excess_s     = intensity - level_s[15:0];
    accept_s     = valid_in && in_ready;
    streak_inc_s = {1'b0, streak_q} + 5'd1;
    det_s        = hit_s && (streak_inc_s >= CONF_C);
    push_s       = accept_s && det_s;
    pop_s        = out_valid && out_ready;

    streak_d = streak_q;
    if (!accept_s) begin
      streak_d = streak_q;
    end else if (hit_s) begin
      streak_d = (streak_inc_s >= CONF_C) ? CONF_C[3:0] : streak_inc_s[3:0];
    end else begin
      streak_d = 4'd0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, streak and sample index; reset discards queued entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 48'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      streak_q <= 4'd0;
      index_q  <= 16'd0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {intensity, excess_s, index_q};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (accept_s) begin
        index_q <= index_q + 16'd1;
      end
      count_q  <= count_d;
      streak_q <= streak_d;
    end
  end

`ifdef CLUTTER_GATE_STATS_EN
  logic [15:0] det_count_q;

  // Saturating count of FIFO pushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_count_q <= 16'd0;
    end else if (push_s && (det_count_q != 16'hFFFF)) begin
      det_count_q <= det_count_q + 16'd1;
    end else begin
      det_count_q <= det_count_q;
    end
  end

  assign det_count = det_count_q;
`endif

endmodule

// File: tb/tb_clutter_gate.sv
// Randomized and directed bench for clutter_gate against a queue-based reference model.
module tb_clutter_gate;

  localparam int DEPTH   = 4;
  localparam int CONFIRM = 3;
  localparam int MARGIN  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic        in_ready;
  logic [15:0] intensity;
  logic [15:0] threshold;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_intensity;
  logic [15:0] out_excess;
  logic [15:0] out_index;
`ifdef CLUTTER_GATE_STATS_EN
  logic [15:0] det_count;
`endif

  always #5 clk = ~clk;

  clutter_gate #(.DEPTH(DEPTH), .CONFIRM(CONFIRM), .MARGIN(16'(MARGIN))) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .in_ready     (in_ready),
    .intensity    (intensity),
    .threshold    (threshold),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_intensity(out_intensity),
    .out_excess   (out_excess),
    .out_index    (out_index)
`ifdef CLUTTER_GATE_STATS_EN
    ,
    .det_count    (det_count)
`endif
  );

  typedef struct {
    int inten;
    int exc;
    int idx;
  } det_t;

  det_t m_fifo[$];
  int   m_index;
  int   m_run;
  int   m_det;
  bit   m_acc;
  int   total = 0;
  int   bad   = 0;

  task automatic model_clear();
    m_fifo.delete();
    m_index = 0;
    m_run   = 0;
    m_det   = 0;
    m_acc   = 1'b0;
  endtask

  // One clock: drive at the falling edge, advance the model, return just after the rising edge.
  task automatic drive_cycle(input bit v, input int inten, input int thr, input bit ordy);
    det_t e;
    bit   hit;
    @(negedge clk);
    valid_in  = v;
    intensity = 16'(inten);
    threshold = 16'(thr);
    out_ready = ordy;
    m_acc = v && (m_fifo.size() < DEPTH);
    if (m_fifo.size() > 0 && ordy) void'(m_fifo.pop_front());
    if (m_acc) begin
      hit = (inten > thr + MARGIN);
      m_run = hit ? m_run + 1 : 0;
      if (hit && m_run >= CONFIRM) begin
        e.inten = inten;
        e.exc   = inten - thr - MARGIN;
        e.idx   = m_index;
        m_fifo.push_back(e);
        m_det++;
      end
      m_index = (m_index + 1) % 65536;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    intensity = 16'd0;
    threshold = 16'd0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if ({out_intensity, out_excess, out_index} !== 48'd0) begin
      bad++; $display("FAIL reset_out_data got=%h/%h/%h want=0/0/0", out_intensity, out_excess, out_index);
    end
`ifdef CLUTTER_GATE_STATS_EN
    total++; if (det_count !== 16'd0) begin bad++; $display("FAIL reset_det_count got=%h want=0", det_count); end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b1);
      total++; if (out_valid !== (k >= 2)) begin bad++; $display("FAIL basic_valid k=%0d got=%0b want=%0b", k, out_valid, (k >= 2)); end
      if (k >= 2) begin
        total++;
        if (out_index !== 16'(k) || out_excess !== 16'h00F1 || out_intensity !== 16'h0200) begin
          bad++; $display("FAIL basic_data k=%0d got=%h/%h/%h want=0200/00f1/%h", k, out_intensity, out_excess, out_index, 16'(k));
        end
      end
    end
`ifdef CLUTTER_GATE_STATS_EN
    total++; if (det_count !== 16'd3) begin bad++; $display("FAIL basic_det_count got=%0d want=3", det_count); end
`endif
  endtask

  task automatic test_pattern();
    bit pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int ndet = 0;
    int last_idx = -1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k < 6) drive_cycle(1'b1, pat[k] ? 32'h200 : 32'h100, 32'h0FF, 1'b1);
      else       drive_cycle(1'b0, 0, 0, 1'b1);
      if (out_valid === 1'b1) begin ndet++; last_idx = int'(out_index); end
    end
    total++; if (ndet != 1) begin bad++; $display("FAIL pattern_count got=%0d want=1", ndet); end
    total++; if (last_idx != 5) begin bad++; $display("FAIL pattern_index got=%0d want=5", last_idx); end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      total++; if (in_ready !== (i < 6)) begin bad++; $display("FAIL bp_in_ready i=%0d got=%0b want=%0b", i, in_ready, (i < 6)); end
      if (in_ready === 1'b1) nacc++;
      drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b0);
    end
    total++; if (nacc != 6) begin bad++; $display("FAIL bp_accepted got=%0d want=6", nacc); end
    total++; if (out_valid !== 1'b1 || out_index !== 16'd2) begin
      bad++; $display("FAIL bp_head got=%0b/%0d want=1/2", out_valid, out_index);
    end
    for (int j = 0; j < 4; j++) begin
      drive_cycle(1'b0, 0, 0, 1'b1);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready j=%0d got=%0b want=1", j, in_ready); end
      total++; if (out_valid !== (j < 3)) begin bad++; $display("FAIL bp_drain_valid j=%0d got=%0b want=%0b", j, out_valid, (j < 3)); end
      if (j < 3) begin
        total++; if (out_index !== 16'(3 + j)) begin bad++; $display("FAIL bp_drain_index j=%0d got=%0d want=%0d", j, out_index, 3 + j); end
      end
    end
  endtask

  task automatic test_boundary();
    int  thr_t[3]  = '{32'hFFF0, 32'h00EF, 32'h00EF};
    int  int_t[3]  = '{32'hFFFF, 32'h00FF, 32'h0100};
    bit  want_t[3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 0, 0, 1'b1);
      drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b1);
      drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b1);
      drive_cycle(1'b1, int_t[c], thr_t[c], 1'b1);
      total++; if (out_valid !== want_t[c]) begin bad++; $display("FAIL boundary_hit c=%0d got=%0b want=%0b", c, out_valid, want_t[c]); end
      if (want_t[c]) begin
        total++; if (out_excess !== 16'd1) begin bad++; $display("FAIL boundary_excess c=%0d got=%h want=0001", c, out_excess); end
      end
      drive_cycle(1'b0, 0, 0, 1'b1);
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      thr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16'hFFD0, 16'hFFFF)) : int'($urandom_range(0, 300));
      drive_cycle(($urandom_range(0, 3) != 0), (thr + int'($urandom_range(0, 40))) % 65536, thr, ($urandom_range(0, 2) != 0));
      total++; if (in_ready !== (m_fifo.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%0b want=%0b", n, in_ready, (m_fifo.size() < DEPTH)); end
      total++; if (out_valid !== (m_fifo.size() > 0)) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%0b want=%0b", n, out_valid, (m_fifo.size() > 0)); end
      if (m_fifo.size() > 0) begin
        total++;
        if ({out_intensity, out_excess, out_index} !== {16'(m_fifo[0].inten), 16'(m_fifo[0].exc), 16'(m_fifo[0].idx)}) begin
          bad++; $display("FAIL rnd_head n=%0d got=%h/%h/%h want=%h/%h/%h", n, out_intensity, out_excess, out_index,
                          16'(m_fifo[0].inten), 16'(m_fifo[0].exc), 16'(m_fifo[0].idx));
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b1);
      if (i == 65535) begin
        total++; if (out_index !== 16'hFFFF) begin bad++; $display("FAIL wrap_last got=%h want=ffff", out_index); end
      end
    end
    total++; if (out_valid !== 1'b1 || out_index !== 16'd0 || out_intensity !== 16'h0200) begin
      bad++; $display("FAIL wrap_index got=%0b/%h/%h want=1/0200/0000", out_valid, out_intensity, out_index);
    end
`ifdef CLUTTER_GATE_STATS_EN
    total++; if (det_count !== 16'((m_det > 65535) ? 65535 : m_det)) begin
      bad++; $display("FAIL wrap_det_count got=%h want=%h", det_count, 16'((m_det > 65535) ? 65535 : m_det));
    end
    repeat (20) drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b1);
    total++; if (det_count !== 16'hFFFF) begin bad++; $display("FAIL sat_det_count got=%h want=ffff", det_count); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b0);
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_pre got=%0b/%0b want=1/1", out_valid, in_ready);
    end
    reset_n  = 1'b0;
    valid_in = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%0b want=1", in_ready); end
    total++; if (out_index !== 16'd0 || out_intensity !== 16'd0) begin
      bad++; $display("FAIL mid_out_data got=%h/%h want=0/0", out_intensity, out_index);
    end
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 32'h200, 32'h0FF, 1'b1);
      total++; if (out_valid !== (k == 2)) begin bad++; $display("FAIL mid_restart_valid k=%0d got=%0b want=%0b", k, out_valid, (k == 2)); end
    end
    total++; if (out_index !== 16'(CONFIRM - 1)) begin bad++; $display("FAIL mid_restart_index got=%0d want=%0d", out_index, CONFIRM - 1); end
  endtask

  initial begin
    reset_n   = 1'b0;
    valid_in  = 1'b0;
    intensity = 16'd0;
    threshold = 16'd0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_pattern();
    test_backpressure();
    test_boundary();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
